// File: rtl/flow_fifo_pkg.sv
// Shared sizing helpers for the flow_fifo family.
// Counter and pointer widths are derived here so every user agrees on them.
package FifoPkg;

  function automatic int fifo_cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_ptr_bits(input int depth);
    int bits;
    bits = $clog2(depth);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/flow_fifo_ptr.sv
// Wrap-around pointer register for flow_fifo: counts 0..p_depth-1 and wraps,
// so depths that are not a power of two work without waste.
module FlowFifoPtr
  import FifoPkg::*;
#(
  parameter int p_depth = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              incr,
  output logic [fifo_ptr_bits(p_depth)-1:0] ptr
);

  localparam int                lp_w    = fifo_ptr_bits(p_depth);
  localparam logic [lp_w-1:0]   lp_last = lp_w'(p_depth - 1);
  localparam logic [lp_w-1:0]   lp_one  = lp_w'(1);

  logic [lp_w-1:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_ptr <= '0;
    end else if (incr) begin
      r_ptr <= (r_ptr == lp_last) ? '0 : r_ptr + lp_one;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/flow_fifo.sv
// Parametrised valid/ready FIFO with occupancy count, almost-full flag and flush.
// Optional same-cycle bypass when built with `FLOW_FIFO_BYPASS_EN defined.
module flow_fifo
  import FifoPkg::*;
#(
  parameter type t_entry        = logic [31:0],
  parameter int  p_depth        = 8,
  parameter int  p_afull_thresh = p_depth - 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              enq_val,
  output logic                              enq_rdy,
  input  t_entry                            enq_msg,
  output logic                              deq_val,
  input  logic                              deq_rdy,
  output t_entry                            deq_msg,
  output logic [fifo_cnt_bits(p_depth)-1:0] count,
  output logic                              almost_full
);

  localparam int                lp_cw     = fifo_cnt_bits(p_depth);
  localparam int                lp_pw     = fifo_ptr_bits(p_depth);
  localparam logic [lp_cw-1:0]  lp_full   = lp_cw'(p_depth);
  localparam logic [lp_cw-1:0]  lp_thresh = lp_cw'(p_afull_thresh);
  localparam logic [lp_cw-1:0]  lp_one    = lp_cw'(1);

  if (p_depth < 2) begin : g_bad_depth
    $error("flow_fifo: p_depth must be at least 2");
  end
  if (p_afull_thresh < 1 || p_afull_thresh > p_depth) begin : g_bad_thresh
    $error("flow_fifo: p_afull_thresh must lie in 1..p_depth");
  end

  // NOTE: the storage array has no reset; only pointers and count define validity.
  t_entry           r_mem [p_depth];
  logic [lp_cw-1:0] r_count;
  logic [lp_pw-1:0] w_wr_ptr;
  logic [lp_pw-1:0] w_rd_ptr;
  logic             w_empty;
  logic             w_stored_val;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic             w_wr_en;
  logic             w_rd_adv;

  assign w_empty      = (r_count == '0);
  assign w_stored_val = !w_empty && !flush;
  assign enq_rdy      = (r_count != lp_full) && !flush;
  assign w_enq_fire   = enq_val && enq_rdy;
  assign w_deq_fire   = deq_val && deq_rdy;

`ifdef FLOW_FIFO_BYPASS_EN
  logic w_pass;

  // An entry arriving at an empty FIFO is offered straight to the consumer.
  assign deq_val  = w_stored_val || (w_empty && enq_val && !flush);
  assign deq_msg  = w_empty ? enq_msg : r_mem[w_rd_ptr];
  assign w_pass   = w_empty && w_enq_fire && w_deq_fire;
  assign w_wr_en  = w_enq_fire && !w_pass;
  assign w_rd_adv = w_deq_fire && !w_pass;
`else
  assign deq_val  = w_stored_val;
  assign deq_msg  = r_mem[w_rd_ptr];
  assign w_wr_en  = w_enq_fire;
  assign w_rd_adv = w_deq_fire;
`endif

  FlowFifoPtr #(.p_depth(p_depth)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .incr  (w_wr_en),
    .ptr   (w_wr_ptr)
  );

  FlowFifoPtr #(.p_depth(p_depth)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .incr  (w_rd_adv),
    .ptr   (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_ptr] <= enq_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
    end else begin
      case ({w_wr_en, w_rd_adv})
        2'b10:   r_count <= r_count + lp_one;
        2'b01:   r_count <= r_count - lp_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count       = r_count;
  assign almost_full = (r_count >= lp_thresh);

endmodule

// File: tb/tb_flow_fifo.sv
// Bench for flow_fifo: a depth-3 (threshold 2) and a depth-4 (default threshold)
// instance share directed stimulus; a queue model checks both every cycle.
module tb_flow_fifo;

`ifdef FLOW_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        enq_val;
  logic [31:0] enq_msg;
  logic        deq_rdy;

  logic        enq_rdy3, deq_val3, afull3;
  logic [31:0] deq_msg3;
  logic [1:0]  count3;
  logic        enq_rdy4, deq_val4, afull4;
  logic [31:0] deq_msg4;
  logic [2:0]  count4;

  int n_cmp  = 0;
  int n_fail = 0;

  bit          model_on = 1'b0;
  bit          log_en   = 1'b0;
  logic [31:0] q3 [$];
  logic [31:0] q4 [$];
  logic [31:0] got3 [$];

  flow_fifo #(.p_depth(3), .p_afull_thresh(2)) u3 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_val     (enq_val),
    .enq_rdy     (enq_rdy3),
    .enq_msg     (enq_msg),
    .deq_val     (deq_val3),
    .deq_rdy     (deq_rdy),
    .deq_msg     (deq_msg3),
    .count       (count3),
    .almost_full (afull3)
  );

  flow_fifo #(.p_depth(4)) u4 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_val     (enq_val),
    .enq_rdy     (enq_rdy4),
    .enq_msg     (enq_msg),
    .deq_val     (deq_val4),
    .deq_rdy     (deq_rdy),
    .deq_msg     (deq_msg4),
    .count       (count4),
    .almost_full (afull4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model rules written from the interface contract, in terms of occupancy only.
  function automatic bit exp_rdy(input int sz, input int depth);
    return (sz != depth) && !flush;
  endfunction

  function automatic bit exp_val(input int sz);
    return ((sz != 0) && !flush) || (BYP && (sz == 0) && enq_val && !flush);
  endfunction

  // Returns {pop, push} for the model queue at the coming edge.
  function automatic logic [1:0] act(input int sz, input int depth);
    bit e, d;
    e = enq_val && exp_rdy(sz, depth);
    d = exp_val(sz) && deq_rdy;
    if (flush) return 2'b00;
    if (BYP && (sz == 0) && e && d) return 2'b00;
    return {d, e};
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      check("u3 count", 32'(count3), 32'(q3.size()));
      check("u3 enq_rdy", 32'(enq_rdy3), 32'(exp_rdy(q3.size(), 3)));
      check("u3 deq_val", 32'(deq_val3), 32'(exp_val(q3.size())));
      check("u3 almost_full", 32'(afull3), 32'(q3.size() >= 2));
      if (exp_val(q3.size()))
        check("u3 deq_msg", deq_msg3, (q3.size() != 0) ? q3[0] : enq_msg);
      check("u4 count", 32'(count4), 32'(q4.size()));
      check("u4 enq_rdy", 32'(enq_rdy4), 32'(exp_rdy(q4.size(), 4)));
      check("u4 deq_val", 32'(deq_val4), 32'(exp_val(q4.size())));
      check("u4 almost_full", 32'(afull4), 32'(q4.size() >= 3));
      if (exp_val(q4.size()))
        check("u4 deq_msg", deq_msg4, (q4.size() != 0) ? q4[0] : enq_msg);
      if (log_en && deq_val3 && deq_rdy) got3.push_back(deq_msg3);
    end
  end

  always @(posedge clk) begin
    logic [1:0] a3, a4;
    if (rst) begin
      q3.delete();
      q4.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      a3 = act(q3.size(), 3);
      a4 = act(q4.size(), 4);
      if (flush) begin
        q3.delete();
        q4.delete();
      end else begin
        if (a3[1]) void'(q3.pop_front());
        if (a3[0]) q3.push_back(enq_msg);
        if (a4[1]) void'(q4.pop_front());
        if (a4[0]) q4.push_back(enq_msg);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ev, input logic [31:0] m, input bit dr);
    enq_val = ev;
    enq_msg = m;
    deq_rdy = dr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drive(0, 0, 0);
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("reset count", 32'(count4), 0);
    check("reset deq_val", 32'(deq_val4), 0);
    check("reset enq_rdy", 32'(enq_rdy4), 1);
    check("reset almost_full", 32'(afull4), 0);
    check("reset count3", 32'(count3), 0);

    // Basic enqueue then dequeue.
    drive(1, 32'hdeadbeef, 0); step(); drive(0, 0, 0); #1;
    check("basic count", 32'(count4), 1);
    check("basic deq_val", 32'(deq_val4), 1);
    check("basic deq_msg", deq_msg4, 32'hdeadbeef);
    drive(0, 0, 1); step(); drive(0, 0, 0); #1;
    check("basic drained count", 32'(count4), 0);
    check("basic drained deq_val", 32'(deq_val4), 0);

    // Fill the depth-3 FIFO; threshold 2 asserts at count 2.
    for (int v = 1; v <= 3; v++) begin
      drive(1, 32'(v), 0); step();
      if (v == 1) check("fill afull at 1", 32'(afull3), 0);
      if (v == 2) check("fill afull at 2", 32'(afull3), 1);
    end
    drive(0, 0, 0); #1;
    check("full count3", 32'(count3), 3);
    check("full enq_rdy3", 32'(enq_rdy3), 0);
    check("full almost_full3", 32'(afull3), 1);
    check("count4 at 3", 32'(count4), 3);
    check("almost_full4 at 3", 32'(afull4), 1);

    // Both sides valid at full: only the dequeue fires on u3.
    drive(1, 4, 1); #1;
    check("full refuses enq", 32'(enq_rdy3), 0);
    step(); drive(0, 0, 0); #1;
    check("full both count3", 32'(count3), 2);
    check("mid both count4", 32'(count4), 3);
    check("full both head3", deq_msg3, 2);
    check("mid both head4", deq_msg4, 2);

    drive(0, 0, 1); step();
    check("drain head3", deq_msg3, 3);
    check("drain head4", deq_msg4, 3);
    step();
    check("drain empty3", 32'(count3), 0);
    check("drain head4 b", deq_msg4, 4);
    step();
    check("drain empty4", 32'(count4), 0);
    drive(0, 0, 0);

    // Simultaneous enqueue/dequeue at count 1 keeps count and order.
    drive(1, 10, 0); step();
    drive(1, 11, 1); step(); drive(0, 0, 0); #1;
    check("count1 both count3", 32'(count3), 1);
    check("count1 both head3", deq_msg3, 11);
    drive(0, 0, 1); step(); drive(0, 0, 0);

    // Wrap-around: ten values through the depth-3 FIFO.
    got3.delete();
    log_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(i), i >= 2); step();
    end
    drive(0, 0, 1);
    repeat (4) step();
    drive(0, 0, 0);
    log_en = 1'b0;
    check("wrap out length", 32'(got3.size()), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < got3.size()) check("wrap out value", got3[i], 32'(i));
    end

    // Flush with a handshake presented in the same cycle.
    drive(1, 20, 0); step();
    drive(1, 21, 0); step();
    flush = 1'b1;
    drive(1, 22, 1); #1;
    check("flush enq_rdy3 low", 32'(enq_rdy3), 0);
    check("flush deq_val3 low", 32'(deq_val3), 0);
    check("flush enq_rdy4 low", 32'(enq_rdy4), 0);
    step();
    flush = 1'b0;
    drive(0, 0, 0); #1;
    check("post flush count3", 32'(count3), 0);
    check("post flush enq_rdy3", 32'(enq_rdy3), 1);
    check("post flush deq_val3", 32'(deq_val3), 0);
    check("post flush count4", 32'(count4), 0);
    drive(1, 23, 0); step(); drive(0, 0, 0); #1;
    check("post flush head3", deq_msg3, 23);
    check("post flush count3 b", 32'(count3), 1);
    drive(0, 0, 1); step(); drive(0, 0, 0);

    // Reset mid-stream.
    drive(1, 30, 0); step();
    rst = 1'b1;
    drive(1, 31, 1); step();
    rst = 1'b0;
    drive(0, 0, 0); #1;
    check("mid reset count3", 32'(count3), 0);
    check("mid reset deq_val3", 32'(deq_val3), 0);
    check("mid reset count4", 32'(count4), 0);

    // Fill the depth-4 FIFO to full.
    for (int v = 40; v <= 43; v++) begin
      drive(1, 32'(v), 0); step();
    end
    drive(0, 0, 0); #1;
    check("full count4", 32'(count4), 4);
    check("full enq_rdy4", 32'(enq_rdy4), 0);
    check("full almost_full4", 32'(afull4), 1);
    check("count3 after 4 pushes", 32'(count3), 3);
    drive(1, 44, 1); step(); drive(0, 0, 0); #1;
    check("full4 both count4", 32'(count4), 3);
    check("full4 head4", deq_msg4, 41);
    drive(0, 0, 1);
    repeat (4) step();
    drive(0, 0, 0);

    // Same-cycle behaviour at an empty FIFO.
    drive(1, 32'h5a, 1); #1;
`ifdef FLOW_FIFO_BYPASS_EN
    check("bypass deq_val3", 32'(deq_val3), 1);
    check("bypass deq_msg3", deq_msg3, 32'h5a);
`else
    check("no bypass deq_val3", 32'(deq_val3), 0);
`endif
    step(); drive(0, 0, 0); #1;
`ifdef FLOW_FIFO_BYPASS_EN
    check("bypass count3", 32'(count3), 0);
`else
    check("no bypass count3", 32'(count3), 1);
    check("no bypass head3", deq_msg3, 32'h5a);
`endif
    drive(0, 0, 1); step(); drive(0, 0, 0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flow_fifo.md
# flow_fifo

Parametrised synchronous FIFO with valid/ready handshakes on both sides, occupancy count, a programmable almost-full flag and a synchronous flush. It succeeds the basic push/pop FIFO in `hw/common`: any depth of at least 2 (not restricted to a power of two), any entry type, and an optional same-cycle bypass. It sits between pipeline stages and memory/network request paths wherever back-pressure and early throttling are needed.

## Interface
- `t_entry`, default `logic [31:0]`: stored entry type.
- `p_depth`, default 8: number of entries, at least 2.
- `p_afull_thresh`, default `p_depth-1`: occupancy at which `almost_full` asserts, from 1 to `p_depth`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous clear of all contents.
- `enq_val` input 1: producer has a valid entry.
- `enq_rdy` output 1: FIFO can accept an entry.
- `enq_msg` input `t_entry`: entry being enqueued.
- `deq_val` output 1: head entry is valid.
- `deq_rdy` input 1: consumer accepts the head.
- `deq_msg` output `t_entry`: head entry.
- `count` output `$clog2(p_depth+1)`: current occupancy.
- `almost_full` output 1: `count >= p_afull_thresh`.

## Operation
- Enqueue fire: `enq_val & enq_rdy`. Dequeue fire: `deq_val & deq_rdy`.
- `enq_rdy = (count != p_depth) & !flush`.
  - There is no combinational path from `deq_rdy` to `enq_rdy`.
  - When full, an enqueue is refused even if a dequeue fires the same cycle.
- `deq_val = (count != 0) & !flush`. `deq_msg` is the storage entry at the read pointer.
  - `deq_msg` is a don't-care while `deq_val=0`.
- Write pointer advances on enqueue fire; read pointer advances on dequeue fire.
  - Each pointer wraps from `p_depth-1` to 0.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on both or neither.
- Simultaneous enqueue and dequeue at any count from 1 to `p_depth-1`: both take effect and `count` is unchanged.
- Empty FIFO: no dequeue fire is possible, so the count can never underflow.
- Flush: at the next edge, both pointers and `count` go to 0. Any handshake presented in the flush cycle is ignored, because both ready/valid signals are forced low.
- Reset: identical effect to flush. Reset has priority over everything.
- Storage array is not reset; contents are don't-care after reset or flush.

## Timing
- Reset values:
  - `count=0`, `deq_val=0`, `enq_rdy=1`, `almost_full=0`.
  - `almost_full=1` out of reset if `p_afull_thresh` equals 0; that value is illegal and must be rejected with an elaboration `$error`.
- Latency without bypass: an entry enqueued at edge N is visible on `deq_msg`/`deq_val` after edge N, so it can dequeue in cycle N+1.
- `count` and `almost_full` reflect state after the last edge; they are combinational only from registers.
- Full throughput: one enqueue and one dequeue per cycle, sustained at any occupancy between empty and full.
- Reset or flush asserted mid-stream: the FIFO is empty from the next cycle. Entries in flight are lost.

## Configuration
- Macro `FLOW_FIFO_BYPASS_EN`.
- Defined, when `count==0` and `enq_val=1` and `flush=0`:
  - `deq_val=1` and `deq_msg=enq_msg` combinationally.
  - If `deq_rdy=1`, the entry passes through; it is not written and `count` stays 0.
  - Otherwise it is stored normally.
- Defined, `enq_rdy` behaviour is unchanged.
- Undefined: no combinational path from `enq_*` to `deq_*`, and the minimum latency is one cycle.

## Structure
- Shared package `FifoPkg`:
  - Function `fifo_cnt_bits(depth)` returning `$clog2(depth+1)`.
  - Function `fifo_ptr_bits(depth)` returning `max(1, $clog2(depth))`.
- Sub-module `FlowFifoPtr`: wrap-around pointer register with `clk`, `rst`, `clear`, `incr` and parameter `p_depth`. Instantiated twice.
- Storage is a flat register array inside `flow_fifo`; there are no SRAM macros.

## Test plan
- Basic: `p_depth=4`, enqueue `'hdeadbeef` → next cycle `deq_val=1`, `deq_msg='hdeadbeef`, `count=1`; dequeue → `count=0`, `deq_val=0`.
- Fill and drain: `p_depth=3`, enqueue 1,2,3 → `enq_rdy=0`, `count=3`, `almost_full=1` (thresh 2 asserted at count 2); dequeue yields 1,2,3 in order.
- Simultaneous at full and mid: at `count=3` with both valid, only the dequeue fires → `count=2`; at `count=1` with both firing → `count` stays 1 and order is preserved.
- Wrap-around: `p_depth=3`, 10 interleaved enqueue/dequeue of values 0..9 → output sequence 0..9 with no loss or duplication.
- Flush/reset mid-operation: `count=2` plus flush together with `enq_val=1` → next cycle `count=0`, the enqueued value is absent, `enq_rdy=1`.
- Bypass (macro defined): empty FIFO, `enq_val=1`, `deq_rdy=1`, `enq_msg='h5a` → same cycle `deq_msg='h5a` and `count` stays 0. Undefined: `deq_val=0` that cycle.
